// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction fetch front end. It keeps one instruction-cache request in
//   flight at a time and steers the fetch PC from the branch predictor or
//   from redirects. Returned instructions go into a small circular queue,
//   and the decode stage drains that queue.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   icache_req_*            fetch request (valid/addr out, ready in)
//   icache_rsp_*            instruction response (valid/data in)
//   bp_hit_i, bp_target_i   predictor result for fetch_pc_o
//   redirect_sel_i          00 none, 01 mispredict_pc_i, 10 alu_pc_i, 11 none
//   dec_*                   head-of-queue entry towards decode
//   fetch_pc_o              current fetch PC
//   stall_o                 a request is outstanding, or the queue is full
//   fetch_count_o           number of instructions handed to decode
//   dbg_state_o             current FSM state (S_REQ=0, S_WAIT=1, S_DROP=2)
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising clock edge. Once valid is asserted it does not depend
// on ready. The exception is icache_req_valid_o, which a same-cycle
// redirect drops.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            icache_req_valid_o,
    output logic [XLEN-1:0] icache_req_addr_o,
    input  logic            icache_req_ready_i,
    input  logic            icache_rsp_valid_i,
    input  logic [ILEN-1:0] icache_rsp_data_i,
    input  logic            bp_hit_i,
    input  logic [XLEN-1:0] bp_target_i,
    input  logic [1:0]      redirect_sel_i,
    input  logic [XLEN-1:0] mispredict_pc_i,
    input  logic [XLEN-1:0] alu_pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [XLEN-1:0] dec_pc4_o,
    output logic [ILEN-1:0] dec_inst_o,
    output logic            dec_hit_o,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic            stall_o,
    output logic [31:0]     fetch_count_o,
    output logic [1:0]      dbg_state_o
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   req_pc_q;
    logic [XLEN-1:0]   req_pc4_q;
    logic              req_hit_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       fetch_count_q;

    logic [XLEN-1:0]   q_pc   [FQ_DEPTH];
    logic [XLEN-1:0]   q_pc4  [FQ_DEPTH];
    logic [ILEN-1:0]   q_inst [FQ_DEPTH];
    logic              q_hit  [FQ_DEPTH];

    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              full;
    logic              empty;
    logic              req_valid;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [XLEN-1:0]   pc_plus4;

    always_comb begin
        redirect    = (redirect_sel_i == 2'b01) || (redirect_sel_i == 2'b10);
        redirect_pc = (redirect_sel_i == 2'b01) ? mispredict_pc_i : alu_pc_i;
        full        = (count_q == CNT_W'(FQ_DEPTH));
        empty       = (count_q == '0);
        pc_plus4    = pc_q + XLEN'(4);
        // A redirect makes the current fetch PC stale, so no request goes out.
        req_valid   = (state_q == S_REQ) && !full && !redirect;
        req_fire    = req_valid && icache_req_ready_i;
        // A redirect discards both the response being pushed and the entry
        // being popped in the same cycle.
        push        = (state_q == S_WAIT) && icache_rsp_valid_i && !redirect;
        pop         = !empty && dec_ready_i && !redirect;
    end

    // Fetch FSM and fetch PC
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            req_pc4_q <= '0;
            req_hit_q <= 1'b0;
        end else begin
            if (redirect) begin
                pc_q <= redirect_pc;
            end else if (req_fire) begin
                pc_q      <= bp_hit_i ? bp_target_i : pc_plus4;
                req_pc_q  <= pc_q;
                req_pc4_q <= pc_plus4;
                req_hit_q <= bp_hit_i;
            end

            case (state_q)
                S_REQ: begin
                    if (req_fire) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // If the response arrives together with the redirect,
                    // it is simply not pushed. Otherwise the response is
                    // still in flight and has to be swallowed in S_DROP.
                    if (icache_rsp_valid_i) state_q <= S_REQ;
                    else if (redirect)      state_q <= S_DROP;
                end
                S_DROP: begin
                    if (icache_rsp_valid_i) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // Queue pointers, occupancy and delivered-instruction counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push && !pop)      count_q <= count_q + CNT_W'(1);
                else if (pop && !push) count_q <= count_q - CNT_W'(1);
            end
            if (pop) fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    // Queue storage. It is not reset because the outputs are zeroed while
    // the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_pc[wr_ptr_q]   <= req_pc_q;
            q_pc4[wr_ptr_q]  <= req_pc4_q;
            q_inst[wr_ptr_q] <= icache_rsp_data_i;
            q_hit[wr_ptr_q]  <= req_hit_q;
        end
    end

    always_comb begin
        icache_req_valid_o = req_valid;
        icache_req_addr_o  = pc_q;
        dec_valid_o        = !empty;
        dec_pc_o           = empty ? '0 : q_pc[rd_ptr_q];
        dec_pc4_o          = empty ? '0 : q_pc4[rd_ptr_q];
        dec_inst_o         = empty ? '0 : q_inst[rd_ptr_q];
        dec_hit_o          = empty ? 1'b0 : q_hit[rd_ptr_q];
        fetch_pc_o         = pc_q;
        stall_o            = (state_q != S_REQ) || full;
        fetch_count_o      = fetch_count_q;
        dbg_state_o        = state_q;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue. A simple instruction-cache responder drives the
// DUT. A transaction-level model follows the DUT: a queue of fetched entries,
// an outstanding flag and a drop flag. The model is compared with the DUT
// outputs on every cycle. Hand-computed literal checks pin key points of
// the model.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        icache_req_valid_o;
    logic [31:0] icache_req_addr_o;
    logic        icache_req_ready_i;
    logic        icache_rsp_valid_i;
    logic [31:0] icache_rsp_data_i;
    logic        bp_hit_i;
    logic [31:0] bp_target_i;
    logic [1:0]  redirect_sel_i;
    logic [31:0] mispredict_pc_i;
    logic [31:0] alu_pc_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_pc4_o;
    logic [31:0] dec_inst_o;
    logic        dec_hit_o;
    logic [31:0] fetch_pc_o;
    logic        stall_o;
    logic [31:0] fetch_count_o;
    logic [1:0]  dbg_state_o;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    if_fetch_queue #(.XLEN(32), .ILEN(32), .FQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .icache_req_valid_o (icache_req_valid_o),
        .icache_req_addr_o  (icache_req_addr_o),
        .icache_req_ready_i (icache_req_ready_i),
        .icache_rsp_valid_i (icache_rsp_valid_i),
        .icache_rsp_data_i  (icache_rsp_data_i),
        .bp_hit_i           (bp_hit_i),
        .bp_target_i        (bp_target_i),
        .redirect_sel_i     (redirect_sel_i),
        .mispredict_pc_i    (mispredict_pc_i),
        .alu_pc_i           (alu_pc_i),
        .dec_valid_o        (dec_valid_o),
        .dec_ready_i        (dec_ready_i),
        .dec_pc_o           (dec_pc_o),
        .dec_pc4_o          (dec_pc4_o),
        .dec_inst_o         (dec_inst_o),
        .dec_hit_o          (dec_hit_o),
        .fetch_pc_o         (fetch_pc_o),
        .stall_o            (stall_o),
        .fetch_count_o      (fetch_count_o),
        .dbg_state_o        (dbg_state_o)
    );

    // ---------------- stimulus settings ----------------
    logic        s_rst = 1'b1;
    logic        s_ready = 1'b0;
    logic        s_dec_rdy = 1'b0;
    logic        s_hit = 1'b0;
    logic [31:0] s_tgt = '0;
    logic [1:0]  s_sel = 2'b00;
    logic [31:0] s_mis = '0;
    logic [31:0] s_alu = '0;
    logic        s_rsp_en = 1'b1;
    logic        s_rsp_force = 1'b0;
    int          s_rsp_lat = 0;

    // cache responder: one slot
    logic        c_pend = 1'b0;
    int          c_age = 0;
    logic [31:0] c_addr = '0;
    logic [31:0] req_log[$];

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        hit;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] m_pc = '0;
    logic        m_out = 1'b0;
    logic        m_drop = 1'b0;
    ent_t        m_req;
    logic [31:0] m_cnt = '0;
    logic        m_init = 1'b0;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Drives one clock cycle, compares outputs with the model and advances
    // the model and the responder. Returns shortly after the rising edge.
    task automatic step();
        logic redir, e_rv, acc, pop, rsp;
        ent_t e;
        @(negedge clk);
        rst_i              = s_rst;
        icache_req_ready_i = s_ready;
        dec_ready_i        = s_dec_rdy;
        bp_hit_i           = s_hit;
        bp_target_i        = s_tgt;
        redirect_sel_i     = s_sel;
        mispredict_pc_i    = s_mis;
        alu_pc_i           = s_alu;
        icache_rsp_valid_i = s_rsp_force || (c_pend && s_rsp_en && (c_age >= s_rsp_lat));
        icache_rsp_data_i  = s_rsp_force ? 32'hBAD0_BAD0 : inst_of(c_addr);
        #1;
        redir = (s_sel == 2'b01) || (s_sel == 2'b10);
        e_rv  = !m_out && !m_drop && (exp_q.size() < DEPTH) && !redir;
        if (m_init) begin
            chk("req_valid", {31'b0, icache_req_valid_o}, {31'b0, e_rv});
            if (e_rv) chk("req_addr", icache_req_addr_o, m_pc);
            chk("dec_valid", {31'b0, dec_valid_o}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("dec_pc", dec_pc_o, exp_q[0].pc);
                chk("dec_pc4", dec_pc4_o, exp_q[0].pc4);
                chk("dec_inst", dec_inst_o, exp_q[0].inst);
                chk("dec_hit", {31'b0, dec_hit_o}, {31'b0, exp_q[0].hit});
            end else begin
                chk("dec_pc_idle", dec_pc_o, 32'h0);
                chk("dec_inst_idle", dec_inst_o, 32'h0);
            end
            chk("fetch_pc", fetch_pc_o, m_pc);
            chk("stall", {31'b0, stall_o},
                {31'b0, m_out || m_drop || (exp_q.size() == DEPTH)});
            chk("fetch_count", fetch_count_o, m_cnt);
        end

        acc = icache_req_valid_o && icache_req_ready_i && !rst_i;
        rsp = icache_rsp_valid_i;
        pop = (exp_q.size() != 0) && s_dec_rdy && !redir;

        // model next state
        if (s_rst) begin
            exp_q.delete();
            m_pc = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_cnt = '0;
            m_init = 1'b1;
        end else if (redir) begin
            exp_q.delete();
            m_pc = (s_sel == 2'b01) ? s_mis : s_alu;
            if (m_out) begin
                m_out  = 1'b0;
                m_drop = !rsp;
            end else if (m_drop && rsp) begin
                m_drop = 1'b0;
            end
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                m_cnt++;
            end
            if (m_out && rsp) begin
                e = m_req;
                e.inst = icache_rsp_data_i;
                exp_q.push_back(e);
                m_out = 1'b0;
            end else if (m_drop && rsp) begin
                m_drop = 1'b0;
            end
            if (e_rv && s_ready) begin
                m_req.pc  = m_pc;
                m_req.pc4 = m_pc + 32'd4;
                m_req.hit = s_hit;
                m_pc = s_hit ? s_tgt : m_pc + 32'd4;
                m_out = 1'b1;
            end
        end

        // cache responder next state
        if (rst_i) begin
            c_pend = 1'b0;
        end else begin
            if (c_pend && rsp && !s_rsp_force) c_pend = 1'b0;
            else if (c_pend) c_age++;
            if (acc) begin
                c_pend = 1'b1;
                c_age  = 0;
                c_addr = icache_req_addr_o;
                req_log.push_back(icache_req_addr_o);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int b;
        rst_i = 1'b1; icache_req_ready_i = 1'b0; icache_rsp_valid_i = 1'b0;
        icache_rsp_data_i = '0; bp_hit_i = 1'b0; bp_target_i = '0;
        redirect_sel_i = 2'b00; mispredict_pc_i = '0; alu_pc_i = '0;
        dec_ready_i = 1'b0;

        // reset
        s_rst = 1'b1; steps(2);
        s_rst = 1'b0;
        chk("rst_dec_valid", {31'b0, dec_valid_o}, 32'd0);
        chk("rst_fetch_count", fetch_count_o, 32'd0);
        chk("rst_fetch_pc", fetch_pc_o, 32'h0);
        chk("rst_dec_pc", dec_pc_o, 32'h0);

        // sequential streaming: response one cycle after acceptance
        s_ready = 1'b1; s_dec_rdy = 1'b1; s_rsp_lat = 0;
        steps(20);
        chk("seq_addr0", req_log[0], 32'h0);
        chk("seq_addr1", req_log[1], 32'h4);
        chk("seq_addr2", req_log[2], 32'h8);
        chk("seq_count", fetch_count_o, 32'd9);

        // back-pressure: the queue fills with exactly FQ_DEPTH entries
        s_ready = 1'b0; steps(4);
        chk("drain_count", fetch_count_o, 32'd10);
        b = req_log.size();
        s_ready = 1'b1; s_dec_rdy = 1'b0; steps(20);
        chk("full_reqs", req_log.size() - b, 32'd4);
        chk("full_first_addr", req_log[b], 32'd40);
        chk("full_stall", {31'b0, stall_o}, 32'd1);
        chk("full_req_valid", {31'b0, icache_req_valid_o}, 32'd0);
        chk("full_dec_valid", {31'b0, dec_valid_o}, 32'd1);
        s_dec_rdy = 1'b1; steps(1);
        s_dec_rdy = 1'b0; steps(6);
        chk("pop_one_req", req_log.size() - b, 32'd5);
        chk("pop_one_count", fetch_count_o, 32'd11);

        // predictor hit at PC 0x8
        s_ready = 1'b0; s_dec_rdy = 1'b1; steps(4);
        s_sel = 2'b01; s_mis = 32'h8; steps(1);
        s_sel = 2'b00; s_ready = 1'b1; s_dec_rdy = 1'b0;
        s_hit = 1'b1; s_tgt = 32'h100; steps(1);
        s_hit = 1'b0; steps(2);
        chk("bp_addr_a", req_log[req_log.size()-2], 32'h8);
        chk("bp_addr_b", req_log[req_log.size()-1], 32'h100);
        chk("bp_dec_pc", dec_pc_o, 32'h8);
        chk("bp_dec_pc4", dec_pc4_o, 32'hC);
        chk("bp_dec_hit", {31'b0, dec_hit_o}, 32'd1);
        chk("bp_dec_inst", dec_inst_o, 32'hDEAD_0008);

        // ALU redirect while waiting: flush, drop the late response
        s_rsp_en = 1'b0; steps(1);
        s_sel = 2'b10; s_alu = 32'h200; steps(1);
        chk("alu_flush", {31'b0, dec_valid_o}, 32'd0);
        chk("alu_drop_stall", {31'b0, stall_o}, 32'd1);
        s_sel = 2'b00; s_rsp_en = 1'b1;
        b = req_log.size();
        steps(4);
        chk("alu_addr", req_log[b], 32'h200);
        chk("alu_dec_pc", dec_pc_o, 32'h200);
        chk("alu_dec_valid", {31'b0, dec_valid_o}, 32'd1);

        // PC wrap at the top of the address space
        s_ready = 1'b0; s_dec_rdy = 1'b1; steps(4);
        s_sel = 2'b01; s_mis = 32'hFFFF_FFFC; steps(1);
        s_sel = 2'b00; s_ready = 1'b1; s_dec_rdy = 1'b0;
        b = req_log.size();
        steps(4);
        chk("wrap_addr_a", req_log[b], 32'hFFFF_FFFC);
        chk("wrap_addr_b", req_log[b+1], 32'h0);
        chk("wrap_dec_pc", dec_pc_o, 32'hFFFF_FFFC);
        chk("wrap_dec_pc4", dec_pc4_o, 32'h0);

        // reset while waiting for a response
        s_dec_rdy = 1'b1; steps(3);
        s_rsp_en = 1'b0; steps(2);
        s_rst = 1'b1; s_ready = 1'b0; steps(1);
        s_rst = 1'b0;
        chk("wrst_dec_valid", {31'b0, dec_valid_o}, 32'd0);
        chk("wrst_fetch_pc", fetch_pc_o, 32'h0);
        chk("wrst_count", fetch_count_o, 32'd0);
        chk("wrst_stall", {31'b0, stall_o}, 32'd0);
        s_rsp_force = 1'b1; steps(1);
        s_rsp_force = 1'b0;
        chk("stale_ignored", {31'b0, dec_valid_o}, 32'd0);
        chk("stale_stall", {31'b0, stall_o}, 32'd0);
        s_rsp_en = 1'b1; s_ready = 1'b1;
        b = req_log.size();
        steps(2);
        chk("wrst_addr", req_log[b], 32'h0);

        // mixed traffic
        for (int i = 0; i < 200; i++) begin
            s_ready   = ($urandom_range(0, 3) != 0);
            s_dec_rdy = $urandom_range(0, 1) == 1;
            s_rsp_lat = $urandom_range(0, 3);
            s_hit     = ($urandom_range(0, 3) == 0);
            s_tgt     = $urandom() & 32'hFFFF_FFFC;
            s_mis     = $urandom() & 32'hFFFF_FFFC;
            s_alu     = $urandom() & 32'hFFFF_FFFC;
            s_sel     = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
